ceespu_mem_arbiter: RTL

CEESPU_MEM_ARBITER -- requirements
Module: ceespu_mem_arbiter

---
 rtl/ceespu_pkg.sv | 23 ++
 rtl/ceespu_mem_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ceespu_pkg.sv
// Shared definitions for the CEESPU memory subsystem: arbiter state encoding,
// bus widths and the default fetch-starvation limit.
package ceespu_pkg;

    localparam int ADDR_W              = 16;
    localparam int DATA_W              = 32;
    localparam int WE_W                = 4;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SERVE_D = 3'd1,
        ST_SERVE_I = 3'd2,
        ST_DONE_D  = 3'd3,
        ST_DONE_I  = 3'd4
    } arbState_t;

    // True while a memory transaction is outstanding on the shared port.
    function automatic logic isServe(input arbState_t s);
        return (s == ST_SERVE_D) || (s == ST_SERVE_I);
    endfunction

endpackage

// File: rtl/ceespu_mem_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one shared memory port.
// Data has priority, but a waiting fetch wins after STARVE_LIMIT data grants.
module ceespu_mem_arbiter
    import ceespu_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                I_clk,
    input  logic                I_rst,

    input  logic                I_imemEnable,
    input  logic [ADDR_W-1:0]   I_imemAddress,
    output logic [DATA_W-1:0]   O_imemData,
    output logic                O_imemBusy,

    input  logic                I_dmemE,
    input  logic [WE_W-1:0]     I_dmemWe,
    input  logic [ADDR_W-1:0]   I_dmemAddress,
    input  logic [DATA_W-1:0]   I_dmemWData,
    output logic [DATA_W-1:0]   O_dmemData,
    output logic                O_dmemBusy,

    output logic                O_memReq,
    output logic [ADDR_W-1:0]   O_memAddress,
    output logic [DATA_W-1:0]   O_memWData,
    output logic [WE_W-1:0]     O_memWe,
    input  logic                I_memAck,
    input  logic [DATA_W-1:0]   I_memRData
);

    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arbState_t        state, stateNext;
    logic [CNT_W-1:0] starveCnt;
    logic             grantD, grantI;
    logic             ackValid;

    assign ackValid = I_memAck && isServe(state);

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) state <= ST_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        grantD    = 1'b0;
        grantI    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (I_dmemE && I_imemEnable) begin
                    if (starveCnt == CNT_MAX) grantI = 1'b1;
                    else                      grantD = 1'b1;
                end else if (I_dmemE) begin
                    grantD = 1'b1;
                end else if (I_imemEnable) begin
                    grantI = 1'b1;
                end
                if (grantD)      stateNext = ST_SERVE_D;
                else if (grantI) stateNext = ST_SERVE_I;
            end
            ST_SERVE_D: if (I_memAck) stateNext = ST_DONE_D;
            ST_SERVE_I: if (I_memAck) stateNext = ST_DONE_I;
            ST_DONE_D,
            ST_DONE_I:  stateNext = ST_IDLE;
            default:    stateNext = ST_IDLE;
        endcase
    end

    // Counts data grants made over a pending fetch; only meaningful in IDLE.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            starveCnt <= '0;
        end else if (state == ST_IDLE) begin
            if (grantI || !I_imemEnable)
                starveCnt <= '0;
            else if (grantD && starveCnt != CNT_MAX)
                starveCnt <= starveCnt + 1'b1;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_memReq     <= 1'b0;
            O_memAddress <= '0;
            O_memWData   <= '0;
            O_memWe      <= '0;
        end else if (grantD) begin
            O_memReq     <= 1'b1;
            O_memAddress <= I_dmemAddress;
            O_memWData   <= I_dmemWData;
            O_memWe      <= I_dmemWe;
        end else if (grantI) begin
            O_memReq     <= 1'b1;
            O_memAddress <= I_imemAddress;
            O_memWData   <= '0;
            O_memWe      <= '0;
        end else if (ackValid) begin
            O_memReq     <= 1'b0;
        end
    end

    // A requester that dropped out mid-transaction gets nothing back.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_dmemData <= '0;
            O_imemData <= '0;
        end else begin
            if (state == ST_SERVE_D && I_memAck && O_memWe == '0 && I_dmemE)
                O_dmemData <= I_memRData;
            if (state == ST_SERVE_I && I_memAck && I_imemEnable)
                O_imemData <= I_memRData;
        end
    end

    assign O_dmemBusy = I_dmemE      & ~(state == ST_DONE_D);
    assign O_imemBusy = I_imemEnable & ~(state == ST_DONE_I);

endmodule
